mul_pack: RTL and testbench

Packing back-end of the floating-point multiplier: the counterpart of the operand unpack stage. Takes the sign, unbounded biased exponent and full-width significand product from the multiplier array and normalizes, denormalizes, rounds, detects overflow/underflow, and assembles the SIGN_W+EXPO_W+MANT_W result word. It is a two-stage pipeline with a valid/ready handshake on both sides.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/mul_round.sv | 37 +++
 rtl/mul_pack.sv | 230 +++++++++++++++++++++++
 tb/tb_mul_pack.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the floating-point multiplier back-end.
//   - default field widths and the derived product width / max exponent
//   - rounding-mode encoding carried on in_rm
//   - exception flag bundle {of, uf, nx}
package mul_pkg;

  localparam int MUL_EXPO_W   = 8;
  localparam int MUL_MANT_W   = 23;
  localparam int MUL_PW       = 2 * (MUL_MANT_W + 1);
  localparam int MUL_EXPO_MAX = (1 << MUL_EXPO_W) - 1;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic of;
    logic uf;
    logic nx;
  } mul_flags_t;

endpackage

// File: rtl/mul_round.sv
// Rounding increment decision and significand increment.
//   sig     : significand to be rounded (hidden bit at MSB)
//   sign    : result sign (selects direction for RDN/RUP)
//   rm      : rounding mode
//   g, s    : guard and sticky bits below the significand LSB
//   sig_rnd : sig plus the increment, wrapped to MANT_W+1 bits
//   carry   : increment carried out of the MSB (significand became 2.0)
module mul_round
  import mul_pkg::*;
#(
  parameter int MANT_W = MUL_MANT_W
) (
  input  logic [MANT_W:0] sig,
  input  logic            sign,
  input  logic [2:0]      rm,
  input  logic            g,
  input  logic            s,
  output logic [MANT_W:0] sig_rnd,
  output logic            carry
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (s | sig[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
    {carry, sig_rnd} = {1'b0, sig} + {{(MANT_W + 1){1'b0}}, inc};
  end

endmodule

// File: rtl/mul_pack.sv
// Packing back-end of the floating-point multiplier.
// Normalizes / denormalizes the raw significand product, rounds, detects
// overflow and underflow, and assembles the packed result word.
// Two-stage pipeline with valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake
//   in_sign, in_expo    : result sign, signed unbounded biased exponent
//   in_mant             : 2*(MANT_W+1)-bit significand product
//   in_zero/inf/nan     : special class, bypasses rounding
//   in_rm               : rounding mode (mul_pkg::rm_e)
//   out_valid/out_ready : output handshake
//   out_z               : packed result {sign, expo, mant}
//   out_of/uf/nx        : overflow, underflow, inexact
module mul_pack
  import mul_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = MUL_EXPO_W,
  parameter int MANT_W = MUL_MANT_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sign,
  input  logic [EXPO_W+1:0]               in_expo,
  input  logic [2*(MANT_W+1)-1:0]         in_mant,
  input  logic                            in_zero,
  input  logic                            in_inf,
  input  logic                            in_nan,
  input  logic [2:0]                      in_rm,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0] out_z,
  output logic                            out_of,
  output logic                            out_uf,
  output logic                            out_nx
);

  localparam int PW     = 2 * (MANT_W + 1);
  localparam int ZW     = SIGN_W + EXPO_W + MANT_W;
  localparam int XW     = EXPO_W + 3;
  localparam int SH_MAX = MANT_W + 3;
  localparam int EXT_W  = MANT_W + 2 + SH_MAX;

  localparam logic signed [XW-1:0] X_ZERO   = '0;
  localparam logic signed [XW-1:0] X_ONE    = XW'(1);
  localparam logic signed [XW-1:0] X_SH_MAX = XW'(SH_MAX);
  localparam logic signed [XW-1:0] X_EMAX   = XW'((1 << EXPO_W) - 1);

  // handshake
  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic rdy_en_q, rdy_en_d;
  logic in_fire, s1_adv;

  // in_ready is held low through reset and for the first edge after it
  assign s1_adv   = vld_p1_q & (~vld_p2_q | out_ready);
  assign in_ready = rdy_en_q & (~vld_p1_q | s1_adv);
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    rdy_en_d = 1'b1;
    vld_p1_d = vld_p1_q;
    if (in_fire)     vld_p1_d = 1'b1;
    else if (s1_adv) vld_p1_d = 1'b0;
    vld_p2_d = vld_p2_q;
    if (s1_adv)         vld_p2_d = 1'b1;
    else if (out_ready) vld_p2_d = 1'b0;
  end

  // ---- stage 0 -> 1: normalize and denormalize ----
  logic signed [XW-1:0] expo_n, sh_amt;
  logic [MANT_W:0]      sig_n;
  logic                 g_n, s_n, tiny_n;
  logic [EXT_W-1:0]     ext_n, ext_sh;

  always_comb begin
    expo_n = {in_expo[EXPO_W+1], in_expo};
    if (in_mant[PW-1]) begin
      sig_n  = in_mant[PW-1 -: MANT_W+1];
      g_n    = in_mant[PW-MANT_W-2];
      s_n    = |in_mant[PW-MANT_W-3:0];
      expo_n = expo_n + X_ONE;
    end else begin
      sig_n  = in_mant[PW-2 -: MANT_W+1];
      g_n    = in_mant[PW-MANT_W-3];
      s_n    = |in_mant[PW-MANT_W-4:0];
    end
    tiny_n = (expo_n <= X_ZERO);
    // beyond SH_MAX everything already lands in sticky
    sh_amt = X_ONE - expo_n;
    if (sh_amt > X_SH_MAX) sh_amt = X_SH_MAX;
    // sticky stays outside the shifted vector so it can never become guard
    ext_n  = {sig_n, g_n, {SH_MAX{1'b0}}};
    ext_sh = ext_n >> sh_amt;
  end

  logic                 sign_p1_q, sign_p1_d;
  logic signed [XW-1:0] expo_p1_q, expo_p1_d;
  logic [MANT_W:0]      sig_p1_q, sig_p1_d;
  logic                 g_p1_q, g_p1_d, s_p1_q, s_p1_d, tiny_p1_q, tiny_p1_d;
  logic [2:0]           rm_p1_q, rm_p1_d;
  logic                 nan_p1_q, nan_p1_d, inf_p1_q, inf_p1_d, zero_p1_q, zero_p1_d;

  always_comb begin
    sign_p1_d = sign_p1_q;
    expo_p1_d = expo_p1_q;
    sig_p1_d  = sig_p1_q;
    g_p1_d    = g_p1_q;
    s_p1_d    = s_p1_q;
    tiny_p1_d = tiny_p1_q;
    rm_p1_d   = rm_p1_q;
    nan_p1_d  = nan_p1_q;
    inf_p1_d  = inf_p1_q;
    zero_p1_d = zero_p1_q;
    if (in_fire) begin
      sign_p1_d = in_sign;
      rm_p1_d   = in_rm;
      nan_p1_d  = in_nan;
      inf_p1_d  = in_inf;
      zero_p1_d = in_zero;
      tiny_p1_d = tiny_n;
      if (tiny_n) begin
        expo_p1_d = X_ZERO;
        sig_p1_d  = ext_sh[EXT_W-1 -: MANT_W+1];
        g_p1_d    = ext_sh[SH_MAX];
        s_p1_d    = s_n | (|ext_sh[SH_MAX-1:0]);
      end else begin
        expo_p1_d = expo_n;
        sig_p1_d  = sig_n;
        g_p1_d    = g_n;
        s_p1_d    = s_n;
      end
    end
  end

  // ---- stage 1 -> 2: round, range check, pack ----
  logic [MANT_W:0]      sig_rnd;
  logic                 rnd_carry;
  logic signed [XW-1:0] expo_f;
  logic                 of_r, maxf_r;
  logic [ZW-1:0]        z_res;
  mul_flags_t           flg_res;

  mul_round #(.MANT_W(MANT_W)) u_round (
    .sig     (sig_p1_q),
    .sign    (sign_p1_q),
    .rm      (rm_p1_q),
    .g       (g_p1_q),
    .s       (s_p1_q),
    .sig_rnd (sig_rnd),
    .carry   (rnd_carry)
  );

  always_comb begin
    // a tiny value promotes to the smallest normal when rounding sets the hidden bit
    expo_f = expo_p1_q + {{(XW-1){1'b0}}, rnd_carry};
    if (tiny_p1_q) expo_f = {{(XW-1){1'b0}}, sig_rnd[MANT_W]};
    of_r   = ~tiny_p1_q & (expo_f >= X_EMAX);
    maxf_r = (rm_p1_q == RM_RTZ) | ((rm_p1_q == RM_RDN) & ~sign_p1_q) |
             ((rm_p1_q == RM_RUP) & sign_p1_q);
    z_res  = {sign_p1_q, expo_f[EXPO_W-1:0], sig_rnd[MANT_W-1:0]};
    if (of_r) begin
      if (maxf_r) z_res = {sign_p1_q, {(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
      else        z_res = {sign_p1_q, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    end
    flg_res.of = of_r;
    flg_res.uf = tiny_p1_q & (g_p1_q | s_p1_q);
    flg_res.nx = g_p1_q | s_p1_q | of_r;
    if (nan_p1_q) begin
      z_res   = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
      flg_res = '0;
    end else if (inf_p1_q) begin
      z_res   = {sign_p1_q, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
      flg_res = '0;
    end else if (zero_p1_q) begin
      z_res   = {sign_p1_q, {(EXPO_W+MANT_W){1'b0}}};
      flg_res = '0;
    end
  end

  logic [ZW-1:0] z_p2_q, z_p2_d;
  mul_flags_t    flg_p2_q, flg_p2_d;

  always_comb begin
    z_p2_d   = z_p2_q;
    flg_p2_d = flg_p2_q;
    if (s1_adv) begin
      z_p2_d   = z_res;
      flg_p2_d = flg_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      z_p2_q   <= '0;
      flg_p2_q <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      z_p2_q   <= z_p2_d;
      flg_p2_q <= flg_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    expo_p1_q <= expo_p1_d;
    sig_p1_q  <= sig_p1_d;
    g_p1_q    <= g_p1_d;
    s_p1_q    <= s_p1_d;
    tiny_p1_q <= tiny_p1_d;
    rm_p1_q   <= rm_p1_d;
    nan_p1_q  <= nan_p1_d;
    inf_p1_q  <= inf_p1_d;
    zero_p1_q <= zero_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_z     = z_p2_q;
  assign out_of    = flg_p2_q.of;
  assign out_uf    = flg_p2_q.uf;
  assign out_nx    = flg_p2_q.nx;

endmodule

// File: tb/tb_mul_pack.sv
// Bench for mul_pack in its FP32 configuration.
module tb_mul_pack;
  import mul_pkg::*;

  localparam int EW = MUL_EXPO_W;
  localparam int MW = MUL_MANT_W;
  localparam int PW = MUL_PW;
  localparam int ZW = 1 + EW + MW;
  localparam logic [ZW-1:0] INF_P = {1'b0, EW'(MUL_EXPO_MAX), {MW{1'b0}}};
  localparam logic [ZW-1:0] INF_N = {1'b1, EW'(MUL_EXPO_MAX), {MW{1'b0}}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [EW+1:0] in_expo = '0;
  logic [PW-1:0] in_mant = '0;
  logic          in_zero = 1'b0, in_inf = 1'b0, in_nan = 1'b0;
  logic [2:0]    in_rm = 3'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [ZW-1:0] out_z;
  logic          out_of, out_uf, out_nx;

  typedef struct {
    logic [ZW-1:0] z;
    logic [2:0]    f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;

  mul_pack #(.SIGN_W(1), .EXPO_W(EW), .MANT_W(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_expo   (in_expo),
    .in_mant   (in_mant),
    .in_zero   (in_zero),
    .in_inf    (in_inf),
    .in_nan    (in_nan),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_of    (out_of),
    .out_uf    (out_uf),
    .out_nx    (out_nx)
  );

  always #5 clk = ~clk;

  // scoreboard: pop and compare every consumed output
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got z=%h with nothing expected", out_z);
      end else begin
        e = sb.pop_front();
        n_out++;
        if (out_z !== e.z || {out_of, out_uf, out_nx} !== e.f) begin
          errors++;
          $display("FAIL sb_result got z=%h f=%b want z=%h f=%b",
                   out_z, {out_of, out_uf, out_nx}, e.z, e.f);
        end
      end
    end
  end

  task automatic send(input logic s, input int e, input logic [PW-1:0] m,
                      input logic [2:0] rm, input logic [2:0] cls,
                      input logic [ZW-1:0] ez, input logic [2:0] ef);
    int t;
    exp_t x;
    t = 0;
    in_sign = s;
    in_expo = e[EW+1:0];
    in_mant = m;
    in_rm   = rm;
    {in_nan, in_inf, in_zero} = cls;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept in_ready=%b want 1", in_ready);
    end else begin
      x.z = ez;
      x.f = ef;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++;
    if (out_z !== '0) begin errors++; $display("FAIL rst_out_z got %h want 0", out_z); end
    checks++;
    if ({out_of, out_uf, out_nx} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b want 000", {out_of, out_uf, out_nx});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    send(1'b0, 127, 48'h900000000000, RM_RNE, 3'b000, 32'h40100000, 3'b000);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_n1 out_valid got %b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_n2 out_valid got %b want 1", out_valid); end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_overflow();
    send(1'b0, 300, 48'h400000000000, RM_RNE, 3'b000, INF_P,        3'b101);
    send(1'b0, 300, 48'h400000000000, RM_RTZ, 3'b000, 32'h7F7FFFFF, 3'b101);
    send(1'b0, 300, 48'h400000000000, RM_RDN, 3'b000, 32'h7F7FFFFF, 3'b101);
    send(1'b0, 300, 48'h400000000000, RM_RUP, 3'b000, INF_P,        3'b101);
    send(1'b1, 300, 48'h400000000000, RM_RDN, 3'b000, INF_N,        3'b101);
    send(1'b1, 300, 48'h400000000000, RM_RUP, 3'b000, 32'hFF7FFFFF, 3'b101);
    // exponent 254 with carry out of rounding reaches 255
    send(1'b0, 254, 48'h7FFFFFC00000, RM_RNE, 3'b000, INF_P,        3'b101);
    wait_drain();
  endtask

  task automatic test_subnormal();
    send(1'b0,    0, 48'h400000000000, RM_RNE, 3'b000, 32'h00400000, 3'b000);
    send(1'b0,  -23, 48'h400000000000, RM_RNE, 3'b000, 32'h00000000, 3'b011);
    send(1'b0,  -23, 48'h400000000000, RM_RUP, 3'b000, 32'h00000001, 3'b011);
    send(1'b0, -400, 48'h400000000000, RM_RUP, 3'b000, 32'h00000001, 3'b011);
    send(1'b1, -400, 48'h400000000000, RM_RNE, 3'b000, 32'h80000000, 3'b011);
    send(1'b0,    0, 48'h7FFFFFC00000, RM_RNE, 3'b000, 32'h00800000, 3'b011);
    wait_drain();
  endtask

  task automatic test_round_modes();
    send(1'b0, 127, 48'h7FFFFFC00000, RM_RNE, 3'b000, 32'h40000000, 3'b001);
    send(1'b1, 127, 48'h400000400000, RM_RNE, 3'b000, 32'hBF800000, 3'b001);
    send(1'b1, 127, 48'h400000400000, RM_RTZ, 3'b000, 32'hBF800000, 3'b001);
    send(1'b1, 127, 48'h400000400000, RM_RDN, 3'b000, 32'hBF800001, 3'b001);
    send(1'b1, 127, 48'h400000400000, RM_RUP, 3'b000, 32'hBF800000, 3'b001);
    send(1'b1, 127, 48'h400000400000, RM_RMM, 3'b000, 32'hBF800001, 3'b001);
    send(1'b1, 127, 48'h400000C00000, RM_RNE, 3'b000, 32'hBF800002, 3'b001);
    send(1'b0, 127, 48'h400000000001, RM_RNE, 3'b000, 32'h3F800000, 3'b001);
    send(1'b0, 127, 48'h400000000001, RM_RUP, 3'b000, 32'h3F800001, 3'b001);
    wait_drain();
  endtask

  task automatic test_specials();
    send(1'b1, 300, 48'h123456789ABC, RM_RNE, 3'b100, 32'h7FC00000, 3'b000);
    send(1'b1, -50, 48'h000000000000, RM_RUP, 3'b010, 32'hFF800000, 3'b000);
    send(1'b0, 300, 48'hFFFFFFFFFFFF, RM_RNE, 3'b010, 32'h7F800000, 3'b000);
    send(1'b1, 300, 48'hFFFFFFFFFFFF, RM_RUP, 3'b001, 32'h80000000, 3'b000);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int acc;
    int n0;
    logic [ZW-1:0] z_hold;
    acc = 0;
    n0 = n_out;
    z_hold = '0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(1'b0, 100 + i, 48'h900000000000, RM_RNE, 3'b000,
               ZW'(((101 + i) << 23) | 32'h00100000), 3'b000);
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
          if (c == 2) z_hold = out_z;
          if (c >= 2) begin
            checks++;
            if (in_ready !== 1'b0) begin
              errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready);
            end
          end
        end
        checks++;
        if (out_valid !== 1'b1 || out_z !== z_hold) begin
          errors++;
          $display("FAIL bp_hold got v=%b z=%h want v=1 z=%h", out_valid, out_z, z_hold);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    checks++;
    if (acc != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", acc); end
    wait_drain();
    checks++;
    if (n_out - n0 != 4) begin errors++; $display("FAIL bp_count got %0d want 4", n_out - n0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [31:0] r;
          logic [7:0]  eb;
          logic        s;
          r  = $urandom;
          eb = 8'($urandom_range(1, 250));
          s  = r[31];
          send(s, int'(eb), {2'b01, r[22:0], 23'd0}, RM_RNE, 3'b000,
               {s, eb, r[22:0]}, 3'b000);
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (n_out - n0 != 12) begin errors++; $display("FAIL b2b_count got %0d want 12", n_out - n0); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    send(1'b0, 127, 48'h900000000000, RM_RNE, 3'b000, 32'h40100000, 3'b000);
    send(1'b0, 128, 48'h900000000000, RM_RNE, 3'b000, 32'h40900000, 3'b000);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_rst_stale cycle %0d out_valid=%b want 0", c, out_valid);
      end
    end
    @(posedge clk);
    #1;
    send(1'b0, 126, 48'h900000000000, RM_RNE, 3'b000, 32'h3F900000, 3'b000);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_subnormal();
    test_round_modes();
    test_specials();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
